// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the register-file writeback path.
//   wb_req_t      : one register-file write request {addr, data}
//   WB_DATA_WIDTH : write data width (32)
//   WB_ADDR_WIDTH : register address width (5)
//   WB_REG_COUNT  : number of architectural registers (32)
// ----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_REG_COUNT  = 32;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_req_t entries used to buffer long-latency results.
// Pointers wrap modulo DEPTH (power of two); the occupancy count is what
// separates full from empty.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : enqueue push_data (ignored when full)
//   push_data  : entry to enqueue
//   pop        : dequeue the head (ignored when empty)
//   pop_data   : current head entry (valid when !empty)
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t        mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
// Merges execute-pipeline writes and buffered long-latency results onto the
// register file's single write port, keeps a pending-write scoreboard for
// decode and forces a one-cycle pipeline stall when buffered results starve.
//
// Optional feature macro: WB_SCOREBOARD_EN
//   defined     : busy_mask tracks issued-but-not-written long-latency dests
//   not defined : busy_mask is tied to 0 and issue_* inputs are ignored
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pipe_valid/rd_addr/data  : execute-pipeline write, never back-pressured
//   mc_valid/ready/rd_addr/rd_data : long-latency result handshake
//   issue_valid/issue_rd_addr: long-latency op issued (scoreboard set)
//   rf_we/rf_rd_addr/rf_rd_data : registered register-file write port
//   busy_mask                : registered pending-write scoreboard
//   pipe_stall               : registered; upstream holds pipe_valid low
//   fifo_count               : current result-buffer occupancy
//
// mc handshake: a transfer happens in every cycle where mc_valid && mc_ready
// are both 1 at the rising edge. mc_ready = !full && !rst and does not look at
// a same-cycle pop. While mc_valid is 1 without mc_ready the producer holds
// mc_rd_addr/mc_rd_data stable. Transfers to register 0 complete but are
// dropped.
//
// Widths DATA_WIDTH/ADDR_WIDTH must match WB_DATA_WIDTH/WB_ADDR_WIDTH, since
// the buffer stores wb_req_t entries.
// ----------------------------------------------------------------------------
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pipe_valid,
    input  logic [ADDR_WIDTH-1:0]        pipe_rd_addr,
    input  logic [DATA_WIDTH-1:0]        pipe_rd_data,
    input  logic                         mc_valid,
    output logic                         mc_ready,
    input  logic [ADDR_WIDTH-1:0]        mc_rd_addr,
    input  logic [DATA_WIDTH-1:0]        mc_rd_data,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd_addr,
    output logic                         rf_we,
    output logic [ADDR_WIDTH-1:0]        rf_rd_addr,
    output logic [DATA_WIDTH-1:0]        rf_rd_data,
    output logic [2**ADDR_WIDTH-1:0]     busy_mask,
    output logic                         pipe_stall,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t    push_req;
    wb_req_t    head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic       pipe_sel;

    logic [SW-1:0] starve_cnt;
    logic          starve_hit;

    // ------------------------------------------------------------------
    // Result buffer
    // ------------------------------------------------------------------
    assign mc_ready      = !fifo_full && !rst;
    assign fifo_push     = mc_valid && mc_ready && (mc_rd_addr != '0);
    assign push_req.addr = mc_rd_addr;
    assign push_req.data = mc_rd_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Arbitration: a real pipe write always wins; a pipe write to r0 is a
    // no-op and leaves the port free for the buffer head.
    // ------------------------------------------------------------------
    assign pipe_sel = pipe_valid && (pipe_rd_addr != '0);
    assign fifo_pop = !pipe_sel && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
        end else begin
            rf_we <= pipe_sel || fifo_pop;
            if (pipe_sel) begin
                rf_rd_addr <= pipe_rd_addr;
                rf_rd_data <= pipe_rd_data;
            end else if (fifo_pop) begin
                rf_rd_addr <= head.addr;
                rf_rd_data <= head.data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation: count cycles where the buffer holds data but loses the
    // port. The cycle that reaches the limit raises pipe_stall for exactly
    // the next cycle, which frees the port for a pop.
    // ------------------------------------------------------------------
    assign starve_hit = !fifo_empty && !fifo_pop &&
                        (starve_cnt == SW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            pipe_stall <= starve_hit;
            if (fifo_empty || fifo_pop || starve_hit) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
`ifdef WB_SCOREBOARD_EN
    logic [2**ADDR_WIDTH-1:0] set_mask;
    logic [2**ADDR_WIDTH-1:0] clr_mask;
    logic [2**ADDR_WIDTH-1:0] busy_next;

    // Set is applied after clear so a same-address set/clear leaves the bit
    // set; bit 0 is forced low because r0 is never written.
    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        if (issue_valid) begin
            set_mask[issue_rd_addr] = 1'b1;
        end
        if (fifo_pop) begin
            clr_mask[head.addr] = 1'b1;
        end
        busy_next    = (busy_mask & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_next;
        end
    end
`else
    logic unused_issue;

    assign busy_mask    = '0;
    assign unused_issue = ^{issue_valid, issue_rd_addr};
`endif

endmodule
